pipe_ctrl_n: RTL and testbench

- Parametrised valid/handshake controller for an NSTAGE-deep in-order pipeline.
- Stage 0 is fetch; stage NSTAGE-1 is writeback.
- Generates per-stage valid bits, inter-stage latch enables and the fetch-advance strobe from per-stage done/hold inputs.
- Beyond a fixed 5-stage controller it adds a partial flush (squash stages 0..flush_idx only), per-stage hold, a fetch-enable gate, occupancy and saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_n_pkg.sv | 19 +
 rtl/pipe_ctrl_n_sat_counter.sv | 34 +++
 rtl/pipe_ctrl_n.sv | 115 +++++++++++
 tb/tb_pipe_ctrl_n.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_n_pkg.sv
// Shared types and helpers for the parametrised pipeline handshake controller.
package pipe_pkg;

  localparam int unsigned NSTAGE_MAX = 16;
  localparam int unsigned DISP_REP   = 4;
  localparam int unsigned OCC_MAX_W  = $clog2(NSTAGE_MAX + 1);

  typedef logic [NSTAGE_MAX-1:0] stage_vec_t;

  function automatic logic [OCC_MAX_W-1:0] popcount(input stage_vec_t v);
    logic [OCC_MAX_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NSTAGE_MAX; i++) begin
      c = c + OCC_MAX_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_n_sat_counter.sv
// Saturating event counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_ctrl_n.sv
// Valid/handshake controller for an NSTAGE-deep in-order pipeline with partial flush,
// per-stage hold, fetch gating, occupancy and saturating stall/flush counters.
module pipe_ctrl_n
  import pipe_pkg::*;
#(
  parameter int unsigned NSTAGE = 5,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned IDX_W  = $clog2(NSTAGE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_en,
  input  logic [NSTAGE-1:0]            stage_over,
  input  logic [NSTAGE-1:0]            stage_hold,
  input  logic                         flush,
  input  logic [IDX_W-1:0]             flush_idx,
  input  logic                         clr_cnt,
  output logic [NSTAGE-1:0]            valid,
  output logic [NSTAGE-1:0]            allow_in,
  output logic [NSTAGE-2:0]            advance,
  output logic                         next_fetch,
  output logic [$clog2(NSTAGE+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt,
  output logic [DISP_REP*NSTAGE-1:0]   valid_disp
);

  localparam int unsigned OCC_W = $clog2(NSTAGE + 1);

  logic [NSTAGE-1:0] valid_q;
  logic [NSTAGE-1:0] valid_d;
  logic [NSTAGE-1:0] go;
  logic [NSTAGE-1:0] squash;
  stage_vec_t        valid_pad;
  logic              stall_inc;

  // flush_idx beyond the last stage squashes everything, so no explicit clamp is needed
  always_comb begin : squash_mask
    squash = '0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      squash[i] = flush && (i <= 32'(flush_idx));
    end
  end

  // Room propagates from writeback toward fetch, so evaluate oldest stage first
  always_comb begin : handshake
    int unsigned s;
    s        = 0;
    go       = '0;
    allow_in = '0;
    go[NSTAGE-1]       = valid_q[NSTAGE-1] & stage_over[NSTAGE-1] & ~stage_hold[NSTAGE-1];
    allow_in[NSTAGE-1] = ~valid_q[NSTAGE-1] | go[NSTAGE-1];
    for (int unsigned j = 2; j <= NSTAGE; j++) begin
      s     = NSTAGE - j;
      go[s] = valid_q[s] & stage_over[s] & ~stage_hold[s] & allow_in[s+1];
      if (s != 0) begin
        allow_in[s] = ~valid_q[s] | go[s];
      end
    end
    next_fetch  = go[0] | flush;
    allow_in[0] = next_fetch;
  end

  assign advance = go[NSTAGE-2:0] & ~squash[NSTAGE-2:0];

  for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
    if (g == 0) begin : g_fetch
      assign valid_d[g] = fetch_en;
    end else begin : g_body
      assign valid_d[g] = squash[g]   ? 1'b0 :
                          allow_in[g] ? advance[g-1] :
                                        valid_q[g];
    end
    assign valid_disp[DISP_REP*(NSTAGE-1-g) +: DISP_REP] = {DISP_REP{valid_q[g]}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

  always_comb begin
    valid_pad                = '0;
    valid_pad[NSTAGE-1:0]    = valid_q;
  end

  assign occupancy = OCC_W'(popcount(valid_pad));
  assign stall_inc = valid_q[0] & ~next_fetch;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (flush),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Self-checking bench for pipe_ctrl_n: a 5-stage and a 2-stage instance against a behavioural model.
module tb_pipe_ctrl_n;

  localparam int unsigned N5   = 5;
  localparam int unsigned N2   = 2;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, fetch_en, flush, clr_cnt;
  logic [N5-1:0] stage_over, stage_hold;
  logic [2:0]    flush_idx;

  logic [4:0]    valid5, allow5;
  logic [3:0]    adv5;
  logic          nf5;
  logic [2:0]    occ5;
  logic [CW-1:0] st5, fl5;
  logic [19:0]   disp5;

  logic [1:0]    valid2, allow2;
  logic [0:0]    adv2;
  logic          nf2;
  logic [1:0]    occ2;
  logic [CW-1:0] st2, fl2;
  logic [7:0]    disp2;

  pipe_ctrl_n #(.NSTAGE(N5), .CNT_W(CW)) u_dut5 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .stage_over(stage_over), .stage_hold(stage_hold),
    .flush(flush), .flush_idx(flush_idx), .clr_cnt(clr_cnt),
    .valid(valid5), .allow_in(allow5), .advance(adv5), .next_fetch(nf5),
    .occupancy(occ5), .stall_cnt(st5), .flush_cnt(fl5), .valid_disp(disp5)
  );

  pipe_ctrl_n #(.NSTAGE(N2), .CNT_W(CW)) u_dut2 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .stage_over(stage_over[1:0]), .stage_hold(stage_hold[1:0]),
    .flush(flush), .flush_idx(flush_idx[0:0]), .clr_cnt(clr_cnt),
    .valid(valid2), .allow_in(allow2), .advance(adv2), .next_fetch(nf2),
    .occupancy(occ2), .stall_cnt(st2), .flush_cnt(fl2), .valid_disp(disp2)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic        m_ok = 1'b0;
  logic [15:0] m_v     [2] = '{16'h0, 16'h0};
  int          m_stall [2] = '{0, 0};
  int          m_flush [2] = '{0, 0};

  task automatic chk(input string name, input int n, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (nstage=%0d) t=%0t got=%h want=%h", name, n, $time, got, exp);
    end
  endtask

  // One cycle of the reference: stages drain oldest-first, each moving when done, not held,
  // and the stage ahead has room (is empty or is itself moving on).
  task automatic model_cycle(input int d);
    int          n, idx;
    logic [15:0] v, go, room, adv, nv;
    logic [63:0] disp;
    logic        nf;
    logic [63:0] g_v, g_a, g_adv, g_nf, g_occ, g_st, g_fl, g_disp;
    n   = (d == 0) ? N5 : N2;
    idx = (d == 0) ? int'(flush_idx) : int'(flush_idx[0]);
    v = m_v[d]; go = '0; room = '0; adv = '0; nv = '0; disp = '0;
    for (int i = n - 1; i >= 0; i--) begin
      go[i]   = v[i] && stage_over[i] && !stage_hold[i] && (i == n - 1 || room[i+1]);
      room[i] = !v[i] || go[i];
    end
    nf      = go[0] || flush;
    room[0] = nf;
    for (int i = 0; i < n - 1; i++) adv[i] = go[i] && !(flush && i <= idx);
    for (int i = 0; i < n; i++) disp[4*(n-1-i) +: 4] = {4{v[i]}};

    if (d == 0) begin
      g_v = 64'(valid5); g_a = 64'(allow5); g_adv = 64'(adv5); g_nf = 64'(nf5);
      g_occ = 64'(occ5); g_st = 64'(st5); g_fl = 64'(fl5); g_disp = 64'(disp5);
    end else begin
      g_v = 64'(valid2); g_a = 64'(allow2); g_adv = 64'(adv2); g_nf = 64'(nf2);
      g_occ = 64'(occ2); g_st = 64'(st2); g_fl = 64'(fl2); g_disp = 64'(disp2);
    end

    if (m_ok) begin
      chk("valid",      n, g_v,    64'(v));
      chk("allow_in",   n, g_a,    64'(room));
      chk("advance",    n, g_adv,  64'(adv));
      chk("next_fetch", n, g_nf,   64'(nf));
      chk("occupancy",  n, g_occ,  64'($countones(v)));
      chk("stall_cnt",  n, g_st,   64'(m_stall[d]));
      chk("flush_cnt",  n, g_fl,   64'(m_flush[d]));
      chk("valid_disp", n, g_disp, disp);
    end

    nv[0] = fetch_en;
    for (int i = 1; i < n; i++) begin
      if (flush && i <= idx) nv[i] = 1'b0;
      else if (room[i])      nv[i] = adv[i-1];
      else                   nv[i] = v[i];
    end
    if (reset) nv = '0;
    m_v[d] = nv;

    if (reset || clr_cnt)                     m_stall[d] = 0;
    else if (v[0] && !nf && m_stall[d] < CMAX) m_stall[d]++;
    if (reset || clr_cnt)                     m_flush[d] = 0;
    else if (flush && m_flush[d] < CMAX)       m_flush[d]++;
  endtask

  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
    if (reset) m_ok = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fetch_en = 1'b1; flush = 1'b0; clr_cnt = 1'b0;
    stage_over = 5'b11111; stage_hold = 5'b00000; flush_idx = 3'd0;
    repeat (2) tick();
    chk("lit_reset_valid", 5, 64'(valid5), 64'd0);
    chk("lit_reset_stall", 5, 64'(st5), 64'd0);
    reset = 1'b0;

    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("lit_fill", 5, 64'(valid5), 64'((1 << k) - 1));
    end
    chk("lit_fill_two", 2, 64'(valid2), 64'd3);
    chk("lit_fill_occ", 5, 64'(occ5), 64'd5);
    chk("lit_fill_stall", 5, 64'(st5), 64'd0);

    stage_hold = 5'b00100;
    #1;
    chk("lit_hold_adv", 5, 64'(adv5), 64'b1000);
    chk("lit_hold_nf", 5, 64'(nf5), 64'd0);
    tick();
    chk("lit_hold_valid1", 5, 64'(valid5), 64'b10111);
    repeat (2) tick();
    chk("lit_hold_valid3", 5, 64'(valid5), 64'b00111);
    chk("lit_hold_stall", 5, 64'(st5), 64'd3);
    stage_hold = 5'b00000;
    tick();
    chk("lit_release1", 5, 64'(valid5), 64'b01111);
    tick();
    chk("lit_release2", 5, 64'(valid5), 64'b11111);

    flush = 1'b1; flush_idx = 3'd2;
    #1;
    chk("lit_flush_nf", 5, 64'(nf5), 64'd1);
    chk("lit_flush_adv", 5, 64'(adv5), 64'b1000);
    tick();
    flush = 1'b0;
    chk("lit_flush_valid", 5, 64'(valid5), 64'b10001);
    chk("lit_flush_cnt", 5, 64'(fl5), 64'd1);
    repeat (4) tick();
    chk("lit_refill", 5, 64'(valid5), 64'b11111);

    flush = 1'b1; flush_idx = 3'd7;
    tick();
    flush = 1'b0;
    chk("lit_full_cancel_en", 5, 64'(valid5), 64'b00001);
    repeat (4) tick();
    flush = 1'b1; fetch_en = 1'b0;
    tick();
    flush = 1'b0; fetch_en = 1'b1;
    chk("lit_full_cancel_dis", 5, 64'(valid5), 64'b00000);
    chk("lit_flush_cnt3", 5, 64'(fl5), 64'd3);
    repeat (5) tick();
    chk("lit_refill2", 5, 64'(valid5), 64'b11111);

    stage_hold = 5'b10000; clr_cnt = 1'b1;
    #1;
    chk("lit_backpressure_adv", 5, 64'(adv5), 64'd0);
    chk("lit_backpressure_nf", 5, 64'(nf5), 64'd0);
    tick();
    clr_cnt = 1'b0;
    chk("lit_clr_beats_inc", 5, 64'(st5), 64'd0);
    repeat (20) tick();
    chk("lit_stall_sat", 5, 64'(st5), 64'hF);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("lit_sat_clr", 5, 64'(st5), 64'd0);
    tick();
    chk("lit_after_clr", 5, 64'(st5), 64'd1);

    stage_hold = 5'b00000; reset = 1'b1; flush = 1'b1; flush_idx = 3'd2;
    tick();
    reset = 1'b0; flush = 1'b0;
    chk("lit_rst_flush_valid", 5, 64'(valid5), 64'd0);
    chk("lit_rst_flush_cnt", 5, 64'(fl5), 64'd0);

    repeat (3000) begin
      fetch_en   = ($urandom_range(0, 7) != 0);
      stage_over = 5'($urandom);
      stage_hold = 5'($urandom & $urandom & $urandom);
      flush      = ($urandom_range(0, 15) == 0);
      flush_idx  = 3'($urandom);
      clr_cnt    = ($urandom_range(0, 63) == 0);
      reset      = ($urandom_range(0, 255) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
